// File: rtl/rename_regfile_ckpt_pkg.sv
// Shared constants for the rename register file and its checkpoint stack.
package rename_regfile_ckpt_pkg;

   localparam int ENTRY_WIDTH_DEF = 4;
   localparam int CKPT_DEPTH_DEF  = 4;
   localparam int CKPT_WIDTH_DEF  = 2;

   localparam logic [ENTRY_WIDTH_DEF-1:0] ENTRY_NULL = '0;
   localparam logic [4:0]                 REG_NULL   = 5'd0;
   localparam logic                       TRUE       = 1'b1;
   localparam logic                       FALSE      = 1'b0;

endpackage

// File: rtl/rename_ckpt_stack.sv
// Circular stack of busy/tag snapshots; commits clear matching tags in every slot.
module rename_ckpt_stack
   import rename_regfile_ckpt_pkg::*;
#(
   parameter int REG_NUM     = 32,
   parameter int ENTRY_WIDTH = ENTRY_WIDTH_DEF,
   parameter int CKPT_DEPTH  = CKPT_DEPTH_DEF,
   parameter int CKPT_WIDTH  = CKPT_WIDTH_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 en,
   input  logic                                 flush,
   input  logic                                 save,
   input  logic [REG_NUM-1:0]                   save_busy,
   input  logic [REG_NUM-1:0][ENTRY_WIDTH-1:0]  save_tag,
   input  logic                                 release_ckpt,
   input  logic                                 restore,
   input  logic [CKPT_WIDTH-1:0]                restore_id,
   input  logic                                 commit_valid,
   input  logic [4:0]                           commit_rd,
   input  logic [ENTRY_WIDTH-1:0]               commit_tag,
   output logic [REG_NUM-1:0]                   restore_busy,
   output logic [REG_NUM-1:0][ENTRY_WIDTH-1:0]  restore_tag,
   output logic                                 ckpt_full,
   output logic [CKPT_WIDTH-1:0]                ckpt_id
);

   logic [CKPT_DEPTH-1:0][REG_NUM-1:0]                  snap_busy;
   logic [CKPT_DEPTH-1:0][REG_NUM-1:0][ENTRY_WIDTH-1:0] snap_tag;
   logic [CKPT_WIDTH-1:0] head, tail, head_rel, diff;
   logic [CKPT_WIDTH:0]   count, count_rel;
   logic                  commit_hit, save_ok, rel_ok;

   assign commit_hit = commit_valid && (commit_rd != REG_NULL);
   assign ckpt_full  = (count == (CKPT_WIDTH+1)'(CKPT_DEPTH));
   assign ckpt_id    = tail;
   assign save_ok    = save && !ckpt_full;
   assign rel_ok     = release_ckpt && (count != '0);
   // release is applied before a same-cycle restore computes the new count
   assign head_rel   = head + CKPT_WIDTH'(rel_ok);
   assign count_rel  = count - (CKPT_WIDTH+1)'(rel_ok);
   assign diff       = restore_id - head_rel;

   always_comb begin
      restore_busy = snap_busy[restore_id];
      restore_tag  = snap_tag[restore_id];
      if (commit_hit && restore_tag[commit_rd] == commit_tag)
         restore_busy[commit_rd] = FALSE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_busy <= '0;
         snap_tag  <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else if (en) begin
         for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
            if (commit_hit && snap_tag[CKPT_WIDTH'(i)][commit_rd] == commit_tag)
               snap_busy[CKPT_WIDTH'(i)][commit_rd] <= FALSE;
         end
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else if (restore) begin
            head  <= head_rel;
            tail  <= restore_id + CKPT_WIDTH'(1);
            count <= (CKPT_WIDTH+1)'(diff) + (CKPT_WIDTH+1)'(1);
         end else begin
            head <= head_rel;
            if (save_ok) begin
               snap_busy[tail] <= save_busy;
               snap_tag[tail]  <= save_tag;
               tail            <= tail + CKPT_WIDTH'(1);
               count           <= count_rel + (CKPT_WIDTH+1)'(1);
            end else begin
               count <= count_rel;
            end
         end
      end
   end

endmodule

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename busy/tag table and checkpointed recovery.
module rename_regfile_ckpt
   import rename_regfile_ckpt_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REG_NUM     = 32,
   parameter int ENTRY_WIDTH = ENTRY_WIDTH_DEF,
   parameter int CKPT_DEPTH  = CKPT_DEPTH_DEF,
   parameter int CKPT_WIDTH  = CKPT_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    issue_valid,
   input  logic [4:0]              issue_rd,
   input  logic [ENTRY_WIDTH-1:0]  issue_rob_id,
   input  logic                    issue_ckpt,
   output logic [CKPT_WIDTH-1:0]   ckpt_id,
   output logic                    ckpt_full,
   input  logic [4:0]              rs1_in,
   input  logic [4:0]              rs2_in,
   output logic [ENTRY_WIDTH-1:0]  Qj,
   output logic [ENTRY_WIDTH-1:0]  Qk,
   output logic                    Bj,
   output logic                    Bk,
   output logic [XLEN-1:0]         Vj,
   output logic [XLEN-1:0]         Vk,
   input  logic                    commit_valid,
   input  logic [4:0]              commit_rd,
   input  logic [ENTRY_WIDTH-1:0]  commit_rob_id,
   input  logic [XLEN-1:0]         commit_value,
   input  logic                    commit_ckpt_release,
   input  logic                    restore_valid,
   input  logic [CKPT_WIDTH-1:0]   restore_id,
   input  logic                    flush
);

   logic [REG_NUM-1:0][XLEN-1:0]        value;
   logic [REG_NUM-1:0]                  busy, busy_nxt, restore_busy;
   logic [REG_NUM-1:0][ENTRY_WIDTH-1:0] tag, tag_nxt, restore_tag;
   logic [1:0]                          src_busy;
   logic [1:0][ENTRY_WIDTH-1:0]         src_tag;
   logic [1:0][XLEN-1:0]                src_val;
   logic                                commit_hit, issue_hit;

   assign commit_hit = commit_valid && (commit_rd != REG_NULL);
   assign issue_hit  = issue_valid && (issue_rd != REG_NULL);

   // post-update table: commit clear first, issue overrides it
   always_comb begin
      busy_nxt = busy;
      tag_nxt  = tag;
      if (commit_hit && tag[commit_rd] == commit_rob_id)
         busy_nxt[commit_rd] = FALSE;
      if (issue_hit) begin
         busy_nxt[issue_rd] = TRUE;
         tag_nxt[issue_rd]  = issue_rob_id;
      end
   end

   always_comb begin
      logic [4:0] rs;
      for (int unsigned p = 0; p < 2; p++) begin
         rs = (p == 0) ? rs1_in : rs2_in;
         src_busy[1'(p)] = FALSE;
         src_tag[1'(p)]  = ENTRY_WIDTH'(ENTRY_NULL);
         src_val[1'(p)]  = '0;
         if (rs != REG_NULL) begin
            src_tag[1'(p)] = tag[rs];
            if (busy[rs] && commit_valid && commit_rd == rs && commit_rob_id == tag[rs])
               src_val[1'(p)] = commit_value;
            else if (busy[rs])
               src_busy[1'(p)] = TRUE;
            else
               src_val[1'(p)] = value[rs];
         end
      end
   end

   assign Bj = src_busy[0];
   assign Bk = src_busy[1];
   assign Qj = src_tag[0];
   assign Qk = src_tag[1];
   assign Vj = src_val[0];
   assign Vk = src_val[1];

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         value <= '0;
         busy  <= '0;
         tag   <= '0;
      end else if (rdy_in) begin
         if (commit_hit)
            value[commit_rd] <= commit_value;
         if (flush) begin
            busy <= '0;
         end else if (restore_valid) begin
            busy <= restore_busy;
            tag  <= restore_tag;
         end else begin
            busy <= busy_nxt;
            tag  <= tag_nxt;
         end
      end
   end

   rename_ckpt_stack #(
      .REG_NUM     (REG_NUM),
      .ENTRY_WIDTH (ENTRY_WIDTH),
      .CKPT_DEPTH  (CKPT_DEPTH),
      .CKPT_WIDTH  (CKPT_WIDTH)
   ) u_ckpt_stack (
      .clk          (clk),
      .rst_n        (rst_in),
      .en           (rdy_in),
      .flush        (flush),
      .save         (issue_ckpt),
      .save_busy    (busy_nxt),
      .save_tag     (tag_nxt),
      .release_ckpt (commit_ckpt_release),
      .restore      (restore_valid),
      .restore_id   (restore_id),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_rob_id),
      .restore_busy (restore_busy),
      .restore_tag  (restore_tag),
      .ckpt_full    (ckpt_full),
      .ckpt_id      (ckpt_id)
   );

endmodule

// File: doc/rename_regfile_ckpt.md
Name: rename_regfile_ckpt

Overview:
- Architectural register file plus rename status table (busy bit and ROB tag per register) for the Tomasulo core.
- Parametrised successor of the single-issue register status block:
  - same-cycle commit bypass on reads;
  - values survive flush;
  - circular stack of rename checkpoints, so a branch mispredict restores the mapping instead of clearing it.
- Sits between decoder/issue and RS/ROB.

Parameters:
XLEN, 32, data width
REG_NUM, 32, architectural registers; x0 hardwired to zero
ENTRY_WIDTH, 4, ROB tag width
CKPT_DEPTH, 4, live checkpoints (power of two)
CKPT_WIDTH, 2, log2(CKPT_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_in  in  1  one clock; reset is asynchronous and active-low
rdy_in  in  1  0 = hold all state
issue_valid  in  1  rename rd this cycle
issue_rd  in  5  destination register
issue_rob_id  in  ENTRY_WIDTH  ROB tag of issuing instr
issue_ckpt  in  1  take checkpoint (branch issue)
ckpt_id  out  CKPT_WIDTH  id allocated if issue_ckpt accepted
ckpt_full  out  1  no free checkpoint
rs1_in, rs2_in  in  5 each  source registers
Qj, Qk  out  ENTRY_WIDTH each  producer tag, valid when busy
Bj, Bk  out  1 each  operand busy
Vj, Vk  out  XLEN each  operand value, 0 when busy
commit_valid  in  1  ROB commit
commit_rd  in  5  committed destination
commit_rob_id  in  ENTRY_WIDTH  committed tag
commit_value  in  XLEN  committed result
commit_ckpt_release  in  1  committed instr is a checkpointed branch; free oldest checkpoint
restore_valid  in  1  mispredict; restore checkpoint
restore_id  in  CKPT_WIDTH  checkpoint to restore
flush  in  1  full recovery (exception)

Behaviour:
- Reset (async, rst_in=0):
  - all value=0, busy=0, tag=0;
  - ckpt head=tail=count=0;
  - outputs reflect empty state: ckpt_full=0, ckpt_id=0, Bj=Bk=0.
- rdy_in=0: no state change; read outputs stay combinational.
- Reads (combinational, zero latency):
  - rs=x0 → B=0, Q=0, V=0.
  - Otherwise, if busy[rs] and commit_valid and commit_rd==rs and commit_rob_id==tag[rs] → bypass: B=0, V=commit_value.
  - Otherwise B=busy[rs], Q=tag[rs], V = busy ? 0 : value[rs].
  - Reads see pre-issue state; rs==issue_rd in the same cycle returns the old mapping.
- Commit (commit_valid, rd≠0):
  - value[rd] <= commit_value unconditionally.
  - busy[rd] cleared only if tag[rd]==commit_rob_id.
  - The same tag-matched clear is applied to every live checkpoint, so restored snapshots never hold stale tags.
- Issue (issue_valid, rd≠0): busy[rd]<=1, tag[rd]<=issue_rob_id. Issue overrides a same-cycle commit clear on the same rd; the value is still written.
- Checkpoint:
  - issue_ckpt and !ckpt_full → snap[tail] <= post-update busy/tag (this cycle's issue and commit applied); ckpt_id=tail; tail++ (wraps); count++.
  - issue_ckpt while ckpt_full → ignored, no state change. Upstream must stall.
  - ckpt_full = (count==CKPT_DEPTH).
- Release: commit_ckpt_release → head++ (wraps), count--. Release with count==0 is ignored.
- Restore (restore_valid):
  - busy/tag <= snap[restore_id] with this cycle's commit clear applied.
  - Any same-cycle issue is discarded (wrong path).
  - tail <= restore_id+1; count <= (restore_id − head) mod CKPT_DEPTH + 1.
  - This keeps the restored checkpoint and frees all younger ones.
  - Release and restore in the same cycle: release applies first. restore_id==old head with release is illegal; result undefined.
- Flush:
  - all busy<=0; values keep commit updates; ckpt head=tail=count=0.
  - Priority: flush > restore > issue/ckpt.
  - Commit value write always applies.
- Writes to x0 ignored everywhere.

Decomposition:
- Shared package: ENTRY_NULL, REG_NULL (x0), TRUE/FALSE, and default ENTRY_WIDTH/CKPT_DEPTH constants.
- Sub-module rename_ckpt_stack:
  - holds CKPT_DEPTH snapshots of busy/tag, head/tail/count, and the per-snapshot commit clear;
  - interface: save, save data, release, restore id, commit rd/tag;
  - outputs: restore data, ckpt_full, ckpt_id.

Test Plan:
- Reset, then issue rd=5 tag=3; read rs1=5 → Bj=1, Qj=3, Vj=0. Commit rd=5 tag=3 value=0x1234 → same-cycle read of rs1=5 gives Bj=0, Vj=0x1234; next cycle the same.
- Issue rd=7 tag=1, then issue rd=7 tag=2; commit rd=7 tag=1 value=9 → value[7]=9, busy stays 1, Qk=2. Issue and commit on rd=7 in the same cycle → busy=1, tag=new.
- Issue rd=4 tag=1; ckpt with branch (id 0); issue rd=4 tag=6; commit tag=1 on rd=4; restore id 0 → busy[4]=0, value = committed value. count: 1 → 1 (restored checkpoint kept, younger ones freed).
- Take 4 checkpoints → ckpt_full=1; 5th issue_ckpt ignored; release → ckpt_full=0, next ckpt_id=0 (wrap).
- Flush with regs 3 and 9 busy and value[3]=0x55 → all B=0, Vj(rs1=3)=0x55, count=0.
- rdy_in=0 with issue/commit asserted → no state change. Async rst_in low mid-cycle → busy clears immediately, without waiting for a clock edge.
